// File: rtl/pix_if.sv
// Pixel-buffer write port: one request at a time, held until acknowledged.
interface pix_if #(
   parameter int ROW_BITS = 7
);
   logic              pix_we;
   logic [7:0]        pix_x;
   logic [ROW_BITS:0] pix_y;
   logic [7:0]        pix_color;
   logic              pix_ack;

   modport master (
      output pix_we, pix_x, pix_y, pix_color,
      input  pix_ack
   );

   modport slave (
      input  pix_we, pix_x, pix_y, pix_color,
      output pix_ack
   );
endinterface

// File: rtl/column_sync_scanout.sv
// Consumer side of the column flag/start handshake. Waits for every column's
// "row computed" flag, snapshots all node_center values, streams them out as
// heat-coloured pixels, then releases the columns into the next row.
module column_sync_scanout #(
   parameter int NUM_COLS = 8,
   parameter int ROW_BITS = 7
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic [ROW_BITS:0]      height,
   input  logic [NUM_COLS-1:0]    col_flag,
   input  logic [NUM_COLS*32-1:0] col_data,
   output logic                   start,
   pix_if.master                  pix,
   output logic [ROW_BITS:0]      row_idx,
   output logic                   sweep_done,
   output logic [15:0]            sweep_count,
   output logic                   busy
);

   localparam int RW    = ROW_BITS + 1;
   localparam int PTR_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam logic [PTR_W-1:0] LAST_COL = PTR_W'(NUM_COLS - 1);

   typedef enum logic [2:0] {
      S_WAIT_FLAGS,
      S_CAPTURE,
      S_WRITE,
      S_START,
      S_WAIT_LOW
   } state_t;

   state_t             state_q;
   logic [31:0]        cap_q [NUM_COLS];
   logic [PTR_W-1:0]   col_ptr_q;
   logic [ROW_BITS:0]  row_idx_q;
   logic [15:0]        sweep_q;
   logic               start_q;
   logic               sweep_done_q;
   logic               we_q;
   logic [7:0]         color_q;

   logic [PTR_W-1:0]   ptr_d;
   logic               wrap_d;
   logic [ROW_BITS:0]  row_d;

   // Signed Q4.27 to 8-bit heat: negatives black, >= 8.0 saturates, else the
   // top eight fraction-adjacent bits give a linear 0.0..<8.0 ramp.
   function automatic logic [7:0] heat(input logic [31:0] v);
      if (v[31])
         return 8'd0;
      else if (v[30])
         return 8'd255;
      else
         return v[29:22];
   endfunction

   assign ptr_d  = col_ptr_q + PTR_W'(1);
   // A height lowered below the current row wraps on the next release.
   assign wrap_d = (row_idx_q >= height);
   assign row_d  = wrap_d ? '0 : row_idx_q + RW'(1);

   // Handshake sequencer; every output below is a register written here.
   // NOTE: state and outputs use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_WAIT_FLAGS;
         col_ptr_q    <= '0;
         row_idx_q    <= '0;
         sweep_q      <= '0;
         start_q      <= 1'b0;
         sweep_done_q <= 1'b0;
         we_q         <= 1'b0;
         color_q      <= '0;
         // NOTE: the capture array is small and its cleared state is visible
         // behaviour, so it is reset like any other register.
         for (int i = 0; i < NUM_COLS; i++) cap_q[i] <= '0;
      end else begin
         start_q      <= 1'b0;
         sweep_done_q <= 1'b0;
         case (state_q)
            S_WAIT_FLAGS: begin
               if ((&col_flag) && run) state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               for (int i = 0; i < NUM_COLS; i++) cap_q[i] <= col_data[32*i +: 32];
               col_ptr_q <= '0;
               we_q      <= 1'b1;
               color_q   <= heat(col_data[31:0]);
               state_q   <= S_WRITE;
            end
            S_WRITE: begin
               if (pix.pix_ack) begin
                  if (col_ptr_q == LAST_COL) begin
                     we_q      <= 1'b0;
                     start_q   <= 1'b1;
                     row_idx_q <= row_d;
                     if (wrap_d) begin
                        sweep_done_q <= 1'b1;
                        sweep_q      <= sweep_q + 16'd1;
                     end
                     state_q <= S_START;
                  end else begin
                     col_ptr_q <= ptr_d;
                     color_q   <= heat(cap_q[ptr_d]);
                  end
               end
            end
            S_START: begin
               state_q <= S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
               // Columns drop their flags a cycle after seeing start; waiting
               // for all-zero keeps a stale flag from retriggering a capture.
               if (~|col_flag) state_q <= S_WAIT_FLAGS;
            end
            default: state_q <= S_WAIT_FLAGS;
         endcase
      end
   end

   assign start         = start_q;
   assign sweep_done    = sweep_done_q;
   assign sweep_count   = sweep_q;
   assign row_idx       = row_idx_q;
   assign busy          = (state_q != S_WAIT_FLAGS);
   assign pix.pix_we    = we_q;
   assign pix.pix_x     = 8'(col_ptr_q);
   assign pix.pix_y     = row_idx_q;
   assign pix.pix_color = color_q;

endmodule

// File: tb/tb_column_sync_scanout.sv
// Bench for column_sync_scanout with four columns and a four-row sweep.
module tb_column_sync_scanout;
   localparam int NC = 4;
   localparam int RB = 7;
   localparam int RW = RB + 1;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             run = 1'b0;
   logic [RB:0]      height = RW'(3);
   logic [NC-1:0]    col_flag = '0;
   logic [NC*32-1:0] col_data = '0;
   logic             start;
   logic [RB:0]      row_idx;
   logic             sweep_done;
   logic [15:0]      sweep_count;
   logic             busy;

   pix_if #(.ROW_BITS(RB)) pix ();

   column_sync_scanout #(.NUM_COLS(NC), .ROW_BITS(RB)) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .height      (height),
      .col_flag    (col_flag),
      .col_data    (col_data),
      .start       (start),
      .pix         (pix.master),
      .row_idx     (row_idx),
      .sweep_done  (sweep_done),
      .sweep_count (sweep_count),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  x;
      logic [RB:0] y;
      logic [7:0]  c;
   } pix_t;

   pix_t exp_q[$];
   pix_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   exp_row = 0;
   int   exp_sweep = 0;
   logic prev_start = 1'b0;

   // Reference colour: treat the word as a signed fixed-point number scaled by 2^27.
   function automatic logic [7:0] heat_ref(input logic [31:0] w);
      longint v = longint'($signed(w));
      if (v < 0) return 8'd0;
      if (v >= 64'sd1073741824) return 8'd255;
      return 8'(v / 4194304);
   endfunction

   // Monitor: accepted pixel writes against the scoreboard, start pulse width.
   always begin
      @(negedge clk);
      #2;
      if (start === 1'b1) begin
         checks++;
         if (prev_start) begin
            failures++;
            $display("FAIL start_width: start high on consecutive cycles");
         end
      end
      prev_start = (start === 1'b1);
      if (pix.pix_we === 1'b1 && pix.pix_ack === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: x=%0d y=%0d c=%0d with empty scoreboard",
                     pix.pix_x, pix.pix_y, pix.pix_color);
         end else begin
            mon_e = exp_q.pop_front();
            if ({pix.pix_x, pix.pix_y, pix.pix_color} !== mon_e) begin
               failures++;
               $display("FAIL pixel: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                        pix.pix_x, pix.pix_y, pix.pix_color, mon_e.x, mon_e.y, mon_e.c);
            end
         end
      end
   end

   // One full row handshake; returns right after the sample that sees start.
   task automatic run_row(input string name, input logic [NC*32-1:0] data,
                          input bit use_colors, input logic [NC*8-1:0] colors,
                          input int stall_at, input int stall_len,
                          input int exp_start, input bit keep_flags);
      int   start_c = 0;
      logic exp_done;
      logic [7:0] stall_col;
      for (int i = 0; i < NC; i++)
         exp_q.push_back('{x: 8'(i), y: RW'(exp_row),
                           c: use_colors ? colors[8*i +: 8] : heat_ref(data[32*i +: 32])});
      stall_col = (stall_at >= 2) ? heat_ref(data[32*(stall_at-2) +: 32]) : 8'd0;
      exp_done = (exp_row >= int'(height));
      exp_row  = exp_done ? 0 : exp_row + 1;
      if (exp_done) exp_sweep = (exp_sweep + 1) % 65536;
      @(negedge clk);
      col_data = data;
      col_flag = '1;
      run = 1'b1;
      pix.pix_ack = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         pix.pix_ack = !(c >= stall_at && c < stall_at + stall_len);
         if (c == 2) col_data = {$urandom, $urandom, $urandom, $urandom};
         #2;
         if (stall_len > 0 && c >= stall_at && c <= stall_at + stall_len) begin
            checks++;
            if (pix.pix_we !== 1'b1 || pix.pix_x !== 8'(stall_at - 2) || pix.pix_color !== stall_col) begin
               failures++;
               $display("FAIL %s hold c%0d: we=%0d x=%0d col=%0d want we=1 x=%0d col=%0d",
                        name, c, pix.pix_we, pix.pix_x, pix.pix_color, stall_at - 2, stall_col);
            end
         end
         if (start === 1'b1) begin
            start_c = c;
            break;
         end
      end
      pix.pix_ack = 1'b1;
      checks++;
      if (start_c != exp_start) begin
         failures++;
         $display("FAIL %s start_cycle: got %0d want %0d (0 = never)", name, start_c, exp_start);
      end
      checks++;
      if (sweep_done !== exp_done) begin
         failures++;
         $display("FAIL %s sweep_done: got %0d want %0d", name, sweep_done, exp_done);
      end
      if (!keep_flags) begin
         @(negedge clk);
         col_flag = '0;
         #2;
         checks++;
         if (row_idx !== RW'(exp_row)) begin
            failures++;
            $display("FAIL %s row_idx: got %0d want %0d", name, row_idx, exp_row);
         end
         checks++;
         if (sweep_count !== 16'(exp_sweep)) begin
            failures++;
            $display("FAIL %s sweep_count: got %0d want %0d", name, sweep_count, exp_sweep);
         end
         @(negedge clk);
         #2;
         checks++;
         if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after: busy=%0d want 0", name, busy);
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s pixels_left: %0d writes missing", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #2;
      checks++;
      if ({start, pix.pix_we, sweep_done, busy} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl: start=%0d we=%0d done=%0d busy=%0d want all 0",
                  start, pix.pix_we, sweep_done, busy);
      end
      checks++;
      if (row_idx !== '0 || sweep_count !== 16'd0 || pix.pix_x !== 8'd0 || pix.pix_color !== 8'd0) begin
         failures++;
         $display("FAIL reset_regs: row=%0d sweeps=%0d x=%0d col=%0d want 0",
                  row_idx, sweep_count, pix.pix_x, pix.pix_color);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_first_row();
      // cols 0..3 = 2.0, 8.0, -1.0, 0.5
      run_row("first_row", {32'h0400_0000, 32'hF800_0000, 32'h4000_0000, 32'h1000_0000},
              1'b1, {8'd16, 8'd0, 8'd255, 8'd64}, 0, 0, NC + 2, 1'b0);
   endtask

   task automatic test_sweep();
      for (int r = 1; r <= 3; r++)
         run_row($sformatf("sweep_row%0d", r), {$urandom, $urandom, $urandom, $urandom},
                 1'b0, '0, 0, 0, NC + 2, 1'b0);
   endtask

   task automatic test_ack_stall();
      run_row("ack_stall", {$urandom, $urandom, 32'h2345_6789, $urandom},
              1'b0, '0, 3, 3, NC + 5, 1'b0);
   endtask

   task automatic test_stuck_flag();
      bit bad = 1'b0;
      run_row("stuck_flag", {$urandom, $urandom, $urandom, $urandom},
              1'b0, '0, 0, 0, NC + 2, 1'b1);
      repeat (20) begin
         @(negedge clk);
         #2;
         if (pix.pix_we !== 1'b0 || start !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL stuck_flag_hold: activity or idle seen while flags stuck high");
      end
      checks++;
      if (row_idx !== RW'(exp_row)) begin
         failures++;
         $display("FAIL stuck_flag_row: got %0d want %0d", row_idx, exp_row);
      end
      @(negedge clk);
      col_flag = '0;
      repeat (2) @(negedge clk);
      #2;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL stuck_flag_release: busy=%0d want 0", busy);
      end
   endtask

   task automatic test_run_gate();
      bit act = 1'b0;
      @(negedge clk);
      col_flag = 4'b1011;
      run = 1'b1;
      repeat (8) begin
         @(negedge clk);
         #2;
         if (busy !== 1'b0 || pix.pix_we !== 1'b0 || start !== 1'b0) act = 1'b1;
      end
      checks++;
      if (act) begin
         failures++;
         $display("FAIL partial_flags: activity with only some flags set");
      end
      act = 1'b0;
      @(negedge clk);
      col_flag = '1;
      run = 1'b0;
      repeat (8) begin
         @(negedge clk);
         #2;
         if (busy !== 1'b0 || pix.pix_we !== 1'b0 || start !== 1'b0) act = 1'b1;
      end
      checks++;
      if (act) begin
         failures++;
         $display("FAIL run_low: activity with run=0");
      end
      run_row("run_gate", {$urandom, $urandom, $urandom, $urandom},
              1'b0, '0, 0, 0, NC + 2, 1'b0);
   endtask

   task automatic test_reset_mid_write();
      bit found = 1'b0;
      for (int i = 0; i < NC; i++)
         exp_q.push_back('{x: 8'(i), y: RW'(exp_row), c: 8'd0});
      @(negedge clk);
      col_data = '0;
      col_flag = '1;
      run = 1'b1;
      pix.pix_ack = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         #2;
         if (pix.pix_we === 1'b1 && pix.pix_x === 8'd2) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL reset_mid_reach: never reached col 2 write");
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({pix.pix_we, start, busy} !== 3'b000) begin
         failures++;
         $display("FAIL reset_async_ctrl: we=%0d start=%0d busy=%0d want 0", pix.pix_we, start, busy);
      end
      checks++;
      if (row_idx !== '0 || sweep_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_async_regs: row=%0d sweeps=%0d want 0", row_idx, sweep_count);
      end
      exp_q.delete();
      exp_row = 0;
      exp_sweep = 0;
      @(negedge clk);
      col_flag = '0;
      @(negedge clk);
      reset = 1'b1;
      run_row("after_reset", {$urandom, $urandom, $urandom, $urandom},
              1'b0, '0, 0, 0, NC + 2, 1'b0);
   endtask

   initial begin
      pix.pix_ack = 1'b0;
      test_reset();
      test_first_row();
      test_sweep();
      test_ack_stall();
      test_stuck_flag();
      test_run_gate();
      test_reset_mid_write();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/column_sync_scanout.md
Name: column_sync_scanout

Overview:
- Consumer side of the column-array flag/start handshake.
- Waits until every column has asserted its "row value computed" flag, then captures each column's node_center value for the current row.
- Converts each captured value to an 8-bit heat colour and streams it as pixel writes into the VGA pixel-buffer write port.
- Then pulses start to release all columns into the next row, tracking row index and completed sweeps.

Parameters:
- NUM_COLS, 8, number of build_column instances served (1..255)
- ROW_BITS, 7, MSB index of row/height fields (row width = ROW_BITS+1)

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- run  in  1  1 = allow handshakes; 0 = hold columns (no new start issued)
- height  in  ROW_BITS+1  index of top row; rows 0..height inclusive
- col_flag  in  NUM_COLS  per-column flag outputs; bit i = column i
- col_data  in  NUM_COLS*32  per-column node_center, signed 32-bit; column i at [32i+31:32i]
- start  out  1  one-cycle release pulse to all columns
- pix_we  out  1  pixel write request
- pix_x  out  8  pixel column (column index)
- pix_y  out  ROW_BITS+1  pixel row (current row index)
- pix_color  out  8  mapped heat colour
- pix_ack  in  1  pixel buffer accepted the current write
- row_idx  out  ROW_BITS+1  row currently being collected
- sweep_done  out  1  one-cycle pulse when the top row has been released
- sweep_count  out  16  completed full-column sweeps, wraps at 65535->0
- busy  out  1  high in CAPTURE, WRITE, START and WAIT_LOW

Behaviour:
- Reset (async, reset=0): state=WAIT_FLAGS, all outputs 0, row_idx=0, col pointer=0, sweep_count=0, captured data cleared. Takes effect immediately, mid-transfer included; any pending pixel write is abandoned.
- States:
  - WAIT_FLAGS: leave when col_flag is all ones AND run=1 -> CAPTURE. If flags are all ones but run=0, stay; nothing is captured.
  - CAPTURE (1 cycle): register all NUM_COLS words from col_data; col pointer=0 -> WRITE. All pixels are taken from these registers; later changes on col_data are ignored.
  - WRITE: pix_we=1; pix_x=col pointer; pix_y=row_idx; pix_color=map(captured[col]).
    - Outputs hold stable until a clock edge with pix_ack=1.
    - On ack: if pointer==NUM_COLS-1 -> START, else increment the pointer.
    - pix_ack while pix_we=0 is ignored.
    - With pix_ack tied high, one pixel is written per cycle.
  - START (1 cycle): start=1.
    - row_idx <= (row_idx==height) ? 0 : row_idx+1.
    - On the wrap to 0: sweep_done=1 for this cycle and sweep_count increments.
    - Then -> WAIT_LOW.
  - WAIT_LOW: columns clear their flags one cycle after sampling start. Stay until col_flag is all zeros, then -> WAIT_FLAGS. This prevents double-counting a stale flag.
- start is never asserted outside START; it is exactly one cycle wide.
- Latency with pix_ack=1 from the all-flags edge: CAPTURE 1 + WRITE NUM_COLS + START 1 cycles. start is high NUM_COLS+2 cycles after the flags are seen.
- Colour map (value is signed Q4.27: bit31 sign, bits30:27 integer, bits26:0 fraction):
  - bit31=1 (negative) -> 0.
  - else bit30=1 (>= 8.0) -> 255.
  - else -> bits[29:22] (linear 0.0..<8.0 onto 0..255).
- height is sampled on each START; changing it mid-sweep takes effect at the next row comparison. If row_idx > new height, the next START wraps to 0.
- Partial flags (some but not all columns set) -> remain in WAIT_FLAGS indefinitely; no timeout.

Test Plan:
- NUM_COLS=4, height=3, pix_ack=1: drive all flags high with col_data = {2.0, 8.0, -1.0, 0.5} (cols 0..3) -> pixel writes at x=0..3, y=0 with colours 64, 255, 0, 16 on consecutive cycles; start pulses 1 cycle at NUM_COLS+2=6 cycles; row_idx becomes 1.
- Flags dropped 1 cycle after start, then reasserted for rows 1, 2, 3 -> after the row-3 start, row_idx=0, sweep_done pulses once, sweep_count=1.
- pix_ack low for 3 cycles on the col-1 write -> pix_x/pix_color held at col-1 values for 4 cycles; start is delayed by 3 cycles.
- Flags held high after start (a column that never clears) -> block stays in WAIT_LOW, no second capture, no second start.
- run=0 with all flags high -> no pix_we and no start; raising run -> capture occurs the next cycle.
- Assert reset=0 mid-WRITE at col 2 -> pix_we, start, row_idx and sweep_count go to 0 immediately (asynchronously); after release, the first capture is row 0.
